wb_data_mem_slave: RTL and testbench

- Pipelined Wishbone B4 responder that models the data memory behind the processor's memory-access stage.
- Serves byte-masked word stores and word reads from an internal word-addressed array.
- Inserts programmable wait states via the stall line and returns exactly one in-order ack per accepted request after a fixed latency.
- Sits at the far end of the data bus: it is the target for the stage's stb/sel/addr/wdata outputs and drives the ack/stall/rdata inputs of that stage.

---
 rtl/wb_data_mem_slave.sv | 109 ++++++++++
 tb/tb_wb_data_mem_slave.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_data_mem_slave.sv
// Pipelined Wishbone B4 data-memory responder: byte-masked word stores, word reads,
// fixed-latency in-order acks and programmable wait states on the stall line.
module wb_data_mem_slave #(
  parameter int ADDR_W      = 10,
  parameter int LATENCY     = 1,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_bus_cyc_data,
  input  logic        wb_stb_data,
  input  logic        wb_w_r_en_data,
  input  logic [31:0] wb_addr_data,
  input  logic [31:0] wb_wdata_data,
  input  logic [3:0]  wb_sel_data,
  output logic        wb_ack_data,
  output logic        wb_stall_data,
  output logic [31:0] wb_rdata_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  word_idx;
  logic               accept;
  logic               stall_reg;
  logic [2:0]         wait_cnt_reg;
  logic [2:0]         wait_cnt_next;
  logic [LATENCY-1:0] valid_reg;
  logic [LATENCY-1:0] is_read_reg;
  logic [31:0]        data_pipe [LATENCY];

  assign word_idx = wb_addr_data[ADDR_W+1:2];
  assign accept   = wb_bus_cyc_data & wb_stb_data & ~stall_reg;

  // Byte offset and bits above the array index alias onto the same word.
  if (ADDR_W < 30) begin : g_unused_hi
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wb_addr_data[31:ADDR_W+2], wb_addr_data[1:0]};
  end else begin : g_unused_lo
    logic unused_addr_bits;
    assign unused_addr_bits = ^wb_addr_data[1:0];
  end

  always_ff @(posedge clk) begin
    if (accept && wb_w_r_en_data) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_data[i]) begin
          mem[word_idx][8*i +: 8] <= wb_wdata_data[8*i +: 8];
        end
      end
    end
  end

  // Stage 0 doubles as the RAM output register; later stages only delay the word.
  always_ff @(posedge clk) begin
    if (accept && !wb_w_r_en_data) begin
      data_pipe[0] <= mem[word_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      data_pipe[i] <= data_pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg   <= '0;
      is_read_reg <= '0;
    end else if (!wb_bus_cyc_data) begin
      valid_reg   <= '0;
      is_read_reg <= '0;
    end else begin
      valid_reg[0]   <= accept;
      is_read_reg[0] <= accept & ~wb_w_r_en_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i]   <= valid_reg[i-1];
        is_read_reg[i] <= is_read_reg[i-1];
      end
    end
  end

  always_comb begin
    wait_cnt_next = '0;
    if (!wb_bus_cyc_data) begin
      wait_cnt_next = '0;
    end else if (accept) begin
      wait_cnt_next = 3'(WAIT_CYCLES);
    end else if (wait_cnt_reg != '0) begin
      wait_cnt_next = wait_cnt_reg - 3'd1;
    end
  end

  // Stall is registered from the next count so it never depends on this cycle's inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      stall_reg    <= 1'b0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      stall_reg    <= (wait_cnt_next != '0);
    end
  end

  assign wb_ack_data   = valid_reg[LATENCY-1];
  assign wb_stall_data = stall_reg;
  assign wb_rdata_data = (valid_reg[LATENCY-1] && is_read_reg[LATENCY-1]) ?
                         data_pipe[LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_wb_data_mem_slave.sv
// Bench for wb_data_mem_slave: three configurations, directed table and sequences,
// plus random traffic checked every cycle against a transaction-level model.
module tb_wb_data_mem_slave;

  // Per-instance configuration {dut2, dut1, dut0}.
  localparam logic [2:0][4:0] AW_P  = {5'd4, 5'd10, 5'd10};
  localparam logic [2:0][2:0] LAT_P = {3'd4, 3'd3, 3'd1};
  localparam logic [2:0][2:0] WC_P  = {3'd2, 3'd0, 3'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       cyc, stb, we, ack, stall;
  logic [2:0][31:0] addr, wdata, rdata;
  logic [2:0][3:0]  sel;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    wb_data_mem_slave #(
      .ADDR_W     (int'(AW_P[gi])),
      .LATENCY    (int'(LAT_P[gi])),
      .WAIT_CYCLES(int'(WC_P[gi]))
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .wb_bus_cyc_data(cyc[gi]),
      .wb_stb_data    (stb[gi]),
      .wb_w_r_en_data (we[gi]),
      .wb_addr_data   (addr[gi]),
      .wb_wdata_data  (wdata[gi]),
      .wb_sel_data    (sel[gi]),
      .wb_ack_data    (ack[gi]),
      .wb_stall_data  (stall[gi]),
      .wb_rdata_data  (rdata[gi])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          dut;
    int          due;
    bit          rd;
    bit          known;
    logic [31:0] data;
  } ent_t;

  ent_t        sq[$];
  logic [31:0] mm    [3][1024];
  bit   [3:0]  kmask [3][1024];
  int          stall_end [3];
  int          e = 0;

  function automatic int widx(int d, logic [31:0] a);
    return int'(a[11:2]) & ((1 << int'(AW_P[d])) - 1);
  endfunction

  // An accepted request at edge e acks in the interval after edge e+LAT-1; stall
  // covers the WAIT intervals following an acceptance; cyc low drops future acks.
  task automatic monitor();
    forever begin
      @(posedge clk);
      e++;
      for (int d = 0; d < 3; d++) begin
        if (rst) begin
          sq = sq.find with (item.dut != d);
          stall_end[d] = -1;
        end else if (!cyc[d]) begin
          sq = sq.find with (item.dut != d || item.due < e);
          stall_end[d] = -1;
        end else if (stb[d] && !((e - 1) <= stall_end[d])) begin
          ent_t t;
          int   ix;
          ix      = widx(d, addr[d]);
          t.dut   = d;
          t.due   = e + int'(LAT_P[d]) - 1;
          t.rd    = !we[d];
          t.known = (kmask[d][ix] == 4'hF);
          t.data  = mm[d][ix];
          if (we[d]) begin
            for (int b = 0; b < 4; b++) begin
              if (sel[d][b]) begin
                mm[d][ix][8*b +: 8] = wdata[d][8*b +: 8];
                kmask[d][ix][b]     = 1'b1;
              end
            end
          end
          sq.push_back(t);
          stall_end[d] = e + int'(WC_P[d]) - 1;
        end
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        int          qi[$];
        bit          ea;
        bit          es;
        logic [31:0] erd;
        logic [31:0] m;
        ea  = 1'b0;
        erd = 32'h0;
        m   = 32'hFFFF_FFFF;
        qi  = sq.find_first_index with (item.dut == d && item.due == e);
        if (qi.size() > 0) begin
          ea = 1'b1;
          if (sq[qi[0]].rd) begin
            if (sq[qi[0]].known) erd = sq[qi[0]].data;
            else                 m   = 32'h0;
          end
          sq.delete(qi[0]);
        end
        es = (e <= stall_end[d]);
        chk({ack[d], stall[d], rdata[d] & m} == {ea, es, erd & m},
            $sformatf("mon_dut%0d_edge%0d", d, e),
            {30'h0, ack[d], stall[d], rdata[d] & m}, {30'h0, ea, es, erd & m});
      end
    end
  endtask

  // ---------------- single-request helper ----------------
  task automatic do_req(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [31:0] exp, input string name);
    int          guard;
    int          lat;
    int          nack;
    logic [31:0] rd;
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = wd;
    guard = 0;
    while (stall[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    lat = 0; nack = 0; rd = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) stb[d] = 1'b0;
      if (ack[d]) begin
        if (nack == 0) begin
          lat = k;
          rd  = rdata[d];
        end
        nack++;
      end
    end
    $display("txn dut%0d %s %s addr=0x%08h sel=%b wdata=0x%08h rdata=0x%08h lat=%0d",
             d, name, w ? "W" : "R", a, s, wd, rd, lat);
    chk(nack == 1, {name, "_ack_count"}, 64'(nack), 64'd1);
    chk(lat == int'(LAT_P[d]), {name, "_latency"}, 64'(lat), 64'(LAT_P[d]));
    chk(rd == exp, {name, "_rdata"}, 64'(rd), 64'(exp));
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [10];
  logic [7:0]  ack_v;
  logic [6:0]  stall_v;
  logic [31:0] rd_v [8];
  int          nack;
  int          acc;

  initial begin
    cyc = '0; stb = '0; we = '0; addr = '0; wdata = '0; sel = '0;
    stall_end = '{-1, -1, -1};

    tbl[0] = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 32'h0000_0012, 4'b0100, 32'h00AA_0000, 32'h0};
    tbl[3] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAA_BEEF};
    tbl[4] = '{1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'h0};
    tbl[5] = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAA_BEEF};
    tbl[6] = '{1'b1, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D, 32'h0};
    tbl[7] = '{1'b1, 32'h0000_0021, 4'b1001, 32'h1122_3344, 32'h0};
    tbl[8] = '{1'b0, 32'h0000_0020, 4'b0000, 32'h0,         32'h11FE_F044};
    tbl[9] = '{1'b0, 32'h0000_1010, 4'b0000, 32'h0,         32'hDEAA_BEEF};

    fork
      monitor();
    join_none

    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk({ack[d], stall[d], rdata[d]} == 34'h0, $sformatf("reset_state_dut%0d", d),
          {30'h0, ack[d], stall[d], rdata[d]}, 64'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Store/load, byte lanes, sel=0000 and aliasing on the LATENCY=1 instance.
    for (int i = 0; i < 10; i++) begin
      do_req(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wd, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // LATENCY=3: three back-to-back reads give three back-to-back in-order acks.
    do_req(1, 1'b1, 32'h0, 4'hF, 32'hA000_0000, 32'h0, "pipe_w0");
    do_req(1, 1'b1, 32'h4, 4'hF, 32'hB111_1111, 32'h0, "pipe_w1");
    do_req(1, 1'b1, 32'h8, 4'hF, 32'hC222_2222, 32'h0, "pipe_w2");
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      ack_v[i] = ack[1];
      rd_v[i]  = rdata[1];
      cyc[1] = 1'b1; we[1] = 1'b0;
      stb[1]  = (i < 3);
      addr[1] = 32'(4 * i);
    end
    $display("txn dut1 pipeline ack_pattern=%b", ack_v);
    chk(ack_v == 8'b0011_1000, "pipe_ack_pattern", 64'(ack_v), 64'h38);
    chk(rd_v[3] == 32'hA000_0000, "pipe_rdata0", 64'(rd_v[3]), 64'hA000_0000);
    chk(rd_v[4] == 32'hB111_1111, "pipe_rdata1", 64'(rd_v[4]), 64'hB111_1111);
    chk(rd_v[5] == 32'hC222_2222, "pipe_rdata2", 64'(rd_v[5]), 64'hC222_2222);

    // WAIT_CYCLES=2: stb held for three requests.
    nack = 0; acc = 0; stall_v = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 7) stall_v[i] = stall[2];
      if (ack[2]) nack++;
      cyc[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
      addr[2] = 32'h14; wdata[2] = 32'(32'h5A00_0000 + acc);
      stb[2] = (acc < 3);
      if (stb[2] && !stall[2]) acc++;
    end
    stb[2] = 1'b0;
    $display("txn dut2 wait_states stall=%b acks=%0d", stall_v, nack);
    chk(stall_v == 7'b011_0110, "wait_stall_pattern", 64'(stall_v), 64'h36);
    chk(acc == 3, "wait_accept_count", 64'(acc), 64'd3);
    chk(nack == 3, "wait_ack_count", 64'(nack), 64'd3);

    // Abort: read accepted, cyc sampled low two edges later, ack never appears.
    do_req(2, 1'b1, 32'h8, 4'hF, 32'hA5A5_0F0F, 32'h0, "abort_setup");
    repeat (3) @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h8;
    nack = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ack[2]) nack++;
      if (i == 1) stb[2] = 1'b0;
      if (i == 2) cyc[2] = 1'b0;
    end
    $display("txn dut2 abort acks=%0d", nack);
    chk(nack == 0, "abort_no_ack", 64'(nack), 64'd0);
    do_req(2, 1'b0, 32'h8, 4'h0, 32'h0, 32'hA5A5_0F0F, "after_abort");

    // ADDR_W=4 aliasing: 0x40 and 0x00 are the same word.
    do_req(2, 1'b1, 32'h40, 4'hF, 32'h600D_F00D, 32'h0, "alias_w");
    do_req(2, 1'b0, 32'h00, 4'h0, 32'h0, 32'h600D_F00D, "alias_r");

    // Reset with a read in flight.
    repeat (3) @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0;
    @(negedge clk);
    stb[2] = 1'b0;
    chk(stall[2] == 1'b1, "prereset_stall", 64'(stall[2]), 64'd1);
    rst = 1'b1;
    #1;
    chk({ack[2], stall[2], rdata[2]} == 34'h0, "reset_immediate",
        {30'h0, ack[2], stall[2], rdata[2]}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack[2]) nack++;
    end
    $display("txn dut2 reset_in_flight late_acks=%0d", nack);
    chk(nack == 0, "reset_no_late_ack", 64'(nack), 64'd0);

    // Random traffic on all instances, checked cycle by cycle by the model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        cyc[d]   = ($urandom_range(0, 15) != 0);
        stb[d]   = $urandom_range(0, 1) != 0;
        we[d]    = $urandom_range(0, 1) != 0;
        addr[d]  = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
        sel[d]   = 4'($urandom_range(0, 15));
        wdata[d] = $urandom();
      end
    end
    @(negedge clk);
    cyc = '0; stb = '0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
